// File: rtl/adc_link_pkg.sv
// Shared definitions for the serial ADC master and its behavioural ADC model.
// Holds the state encodings of both FSMs, the command bit constants and the sample width.
package adc_link_pkg;

   localparam int DATA_W = 10;

   localparam logic CMD_START = 1'b1;
   localparam logic CMD_SGL   = 1'b1;
   localparam logic CMD_MSBF  = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_START = 4'd1,
      S_SGL   = 4'd2,
      S_ODD   = 4'd3,
      S_MSBF  = 4'd4,
      S_NULL  = 4'd5,
      S_RX    = 4'd6,
      S_DONE  = 4'd7,
      S_WAIT  = 4'd8
   } serial_state_t;

   typedef enum logic [3:0] {
      A_IDLE = 4'd0,
      A_CFG  = 4'd1,
      A_NULL = 4'd2,
      A_TX   = 4'd3,
      A_DONE = 4'd4
   } adc_state_t;

endpackage

// File: rtl/adc_sim.sv
// Behavioural MCP3002-style ADC: decodes the command and answers with an
// incrementing sample, releasing Dout whenever it is not transmitting.
module adc_sim
   import adc_link_pkg::*;
#(
   parameter logic [DATA_W-1:0] INIT = 10'h295
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Din,
   input  logic              cs,
   output logic              Dout,
   output logic [3:0]        recd_tp,
   output logic [3:0]        state,
   output logic [DATA_W-1:0] counter
);

   adc_state_t        st;
   logic [3:0]        idx;
   logic [DATA_W-1:0] tx_sh;

   // A master deselect mid-frame abandons the frame without consuming the sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= A_IDLE;
         recd_tp <= '0;
         counter <= INIT;
         idx     <= '0;
         tx_sh   <= '0;
      end else if (cs && st != A_IDLE && st != A_DONE) begin
         st  <= A_IDLE;
         idx <= '0;
      end else begin
         case (st)
            A_IDLE: begin
               if (!cs && Din) begin
                  st         <= A_CFG;
                  recd_tp[3] <= Din;
                  idx        <= '0;
               end
            end
            A_CFG: begin
               recd_tp[2:0] <= {recd_tp[1:0], Din};
               idx          <= idx + 4'd1;
               if (idx == 4'd2) begin
                  st  <= A_NULL;
                  idx <= '0;
               end
            end
            A_NULL: begin
               st    <= A_TX;
               tx_sh <= counter;
               idx   <= '0;
            end
            A_TX: begin
               tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
               idx   <= idx + 4'd1;
               if (idx == 4'(DATA_W - 1)) begin
                  st  <= A_DONE;
                  idx <= '0;
               end
            end
            A_DONE: begin
               counter <= counter + 1'b1;
               st      <= A_IDLE;
            end
            default: st <= A_IDLE;
         endcase
      end
   end

   assign Dout  = (st == A_NULL) ? 1'b0 :
                  (st == A_TX)   ? tx_sh[DATA_W-1] : 1'bz;
   assign state = st;

endmodule

// File: rtl/serial.sv
// SPI-style master for a 10-bit ADC: sends a 4-bit command, skips the null bit,
// shifts in 10 data bits MSB first and pulses ready with the result.
module serial
   import adc_link_pkg::*;
#(
   parameter logic CH  = 1'b0,
   parameter int   GAP = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              cs,
   output logic              Din,
   input  logic              Dout,
   output logic              ready,
   output logic [DATA_W-1:0] data,
   output logic [3:0]        state,
   output logic [DATA_W-1:0] time_out
);

   serial_state_t       st;
   logic [DATA_W-2:0]   shreg;
   logic [3:0]          bit_cnt;

   // The final data bit is merged straight into data, so the result is valid with ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_IDLE;
         data     <= '0;
         time_out <= '0;
         shreg    <= '0;
         bit_cnt  <= '0;
      end else begin
         case (st)
            S_IDLE:  if (en) st <= S_START;
            S_START: st <= S_SGL;
            S_SGL:   st <= S_ODD;
            S_ODD:   st <= S_MSBF;
            S_MSBF:  st <= S_NULL;
            S_NULL: begin
               st      <= S_RX;
               bit_cnt <= '0;
            end
            S_RX: begin
               shreg   <= {shreg[DATA_W-3:0], Dout};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'(DATA_W - 1)) begin
                  st   <= S_DONE;
                  data <= {shreg, Dout};
               end
            end
            S_DONE: begin
               st       <= S_WAIT;
               time_out <= '0;
            end
            S_WAIT: begin
               if (time_out == DATA_W'(GAP - 1)) begin
                  time_out <= '0;
                  st       <= en ? S_START : S_IDLE;
               end else begin
                  time_out <= time_out + 1'b1;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      cs    = 1'b1;
      Din   = 1'b0;
      ready = 1'b0;
      case (st)
         S_START: begin cs = 1'b0; Din = CMD_START; end
         S_SGL:   begin cs = 1'b0; Din = CMD_SGL;   end
         S_ODD:   begin cs = 1'b0; Din = CH;        end
         S_MSBF:  begin cs = 1'b0; Din = CMD_MSBF;  end
         S_NULL:  cs = 1'b0;
         S_RX:    cs = 1'b0;
         S_DONE:  ready = 1'b1;
         default: ;
      endcase
   end

   assign state = st;

endmodule

// File: rtl/adc_serial_link.sv
// Master and ADC model wired together on one clock; internal link signals and
// both FSM states are brought out for observation.
module adc_serial_link
   import adc_link_pkg::*;
#(
   parameter logic              CH   = 1'b0,
   parameter int                GAP  = 20,
   parameter logic [DATA_W-1:0] INIT = 10'h295
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              cs,
   output logic              Din,
   output logic              Dout,
   output logic              ready,
   output logic [DATA_W-1:0] data,
   output logic [3:0]        serial_state,
   output logic [DATA_W-1:0] time_out,
   output logic [3:0]        recd_tp,
   output logic [3:0]        adc_state,
   output logic [DATA_W-1:0] counter
);

   serial #(.CH(CH), .GAP(GAP)) u_serial (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cs       (cs),
      .Din      (Din),
      .Dout     (Dout),
      .ready    (ready),
      .data     (data),
      .state    (serial_state),
      .time_out (time_out)
   );

   adc_sim #(.INIT(INIT)) u_adc (
      .clk     (clk),
      .rst     (rst),
      .Din     (Din),
      .cs      (cs),
      .Dout    (Dout),
      .recd_tp (recd_tp),
      .state   (adc_state),
      .counter (counter)
   );

endmodule

// File: tb/tb_adc_serial_link.sv
// Self-checking bench for adc_serial_link: a frame vector table, directed
// multi-cycle sequences and a randomized run against a frame-timeline model.
module tb_adc_serial_link;

   localparam int GAP = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;

   logic       cs, Din, Dout, ready;
   logic [9:0] data, time_out, counter;
   logic [3:0] serial_state, recd_tp, adc_state;

   logic       w_cs, w_Din, w_Dout, w_ready;
   logic [9:0] w_data, w_time_out, w_counter;
   logic [3:0] w_serial_state, w_recd_tp, w_adc_state;

   adc_serial_link #(.CH(1'b0), .GAP(GAP), .INIT(10'h295)) u_dut (
      .clk(clk), .rst(rst), .en(en), .cs(cs), .Din(Din), .Dout(Dout),
      .ready(ready), .data(data), .serial_state(serial_state), .time_out(time_out),
      .recd_tp(recd_tp), .adc_state(adc_state), .counter(counter)
   );

   adc_serial_link #(.CH(1'b0), .GAP(GAP), .INIT(10'h3FF)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .cs(w_cs), .Din(w_Din), .Dout(w_Dout),
      .ready(w_ready), .data(w_data), .serial_state(w_serial_state), .time_out(w_time_out),
      .recd_tp(w_recd_tp), .adc_state(w_adc_state), .counter(w_counter)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int   off;
      logic cs;
      logic din;
      logic dout_chk;
      logic dout;
      logic ready;
   } vec_t;

   vec_t vecs[16];

   // Frame timeline model: off counts edges since the edge that sampled en
   int off;
   int samp_a, samp_b, dexp_a, dexp_b;
   logic [3:0] din_seq;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic r, input logic e);
      rst = r;
      en  = e;
      @(posedge clk);
      #1;
   endtask

   task automatic modelStep(input logic r, input logic e);
      if (r) begin
         off    = 0;
         samp_a = 'h295;
         samp_b = 'h3FF;
         dexp_a = 0;
         dexp_b = 0;
      end else if (off == 0 || off == 16 + GAP) begin
         off = e ? 1 : 0;
      end else begin
         if (off == 16) begin
            samp_a = (samp_a + 1) % 1024;
            samp_b = (samp_b + 1) % 1024;
         end
         off++;
      end
      if (off == 16) begin
         dexp_a = samp_a;
         dexp_b = samp_b;
      end
   endtask

   task automatic resetDut();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
   endtask

   initial begin
      logic [10:0] dout_seq;
      int r1, r2, d1, d2, wd1, wd2, max_to, high_run, gap_run, low_cnt, rdy_cnt;
      bit seen_low;
      logic r, e;

      din_seq  = 4'b1101;
      dout_seq = 11'b0_1010010101;
      for (int i = 0; i < 16; i++) begin
         vecs[i].off      = i + 1;
         vecs[i].cs       = (i + 1 <= 15) ? 1'b0 : 1'b1;
         vecs[i].din      = (i + 1 <= 4) ? din_seq[3 - i] : 1'b0;
         vecs[i].dout_chk = (i + 1 >= 5 && i + 1 <= 15);
         vecs[i].dout     = (i + 1 >= 5 && i + 1 <= 15) ? dout_seq[14 - i] : 1'b0;
         vecs[i].ready    = (i + 1 == 16);
      end

      // Reset values
      resetDut();
      checkOutput("rst_cs", cs, 1);
      checkOutput("rst_din", Din, 0);
      checkOutput("rst_ready", ready, 0);
      checkOutput("rst_data", data, 0);
      checkOutput("rst_time_out", time_out, 0);
      checkOutput("rst_sstate", serial_state, 0);
      checkOutput("rst_astate", adc_state, 0);
      checkOutput("rst_recd_tp", recd_tp, 0);
      checkOutput("rst_counter", counter, 'h295);
      checkOutput("rst_w_counter", w_counter, 'h3FF);

      // Single conversion against the frame table
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, (i == 0));
         checkOutput($sformatf("frame_cs_%0d", vecs[i].off), cs, vecs[i].cs);
         checkOutput($sformatf("frame_din_%0d", vecs[i].off), Din, vecs[i].din);
         checkOutput($sformatf("frame_ready_%0d", vecs[i].off), ready, vecs[i].ready);
         if (vecs[i].dout_chk)
            checkOutput($sformatf("frame_dout_%0d", vecs[i].off), Dout, vecs[i].dout);
      end
      checkOutput("frame_data", data, 'h295);
      checkOutput("frame_recd_tp", recd_tp, 4'b1101);
      applyStimulus(1'b0, 1'b0);
      checkOutput("frame_counter", counter, 'h296);
      checkOutput("frame_ready_off", ready, 0);
      checkOutput("frame_data_hold", data, 'h295);
      for (int i = 0; i < 22; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("frame_idle", serial_state, 0);

      // Continuous conversions with en held
      resetDut();
      r1 = -1; r2 = -1; d1 = 0; d2 = 0; wd1 = 0; wd2 = 0;
      max_to = 0; high_run = 0; gap_run = -1; seen_low = 0;
      for (int i = 1; i <= 80; i++) begin
         applyStimulus(1'b0, 1'b1);
         if (ready) begin
            if (r1 < 0) begin r1 = i; d1 = data; wd1 = w_data; end
            else if (r2 < 0) begin r2 = i; d2 = data; wd2 = w_data; end
         end
         if (int'(time_out) > max_to) max_to = time_out;
         if (!cs) begin
            if (seen_low && high_run > 0 && gap_run < 0) gap_run = high_run;
            seen_low = 1;
            high_run = 0;
         end else if (seen_low) begin
            high_run++;
         end
      end
      checkOutput("cont_first_ready", r1, 16);
      checkOutput("cont_period", r2 - r1, 16 + GAP);
      checkOutput("cont_data1", d1, 'h295);
      checkOutput("cont_data2", d2, 'h296);
      checkOutput("wrap_data1", wd1, 'h3FF);
      checkOutput("wrap_data2", wd2, 'h000);
      checkOutput("cont_max_time_out", max_to, GAP - 1);
      checkOutput("cont_cs_gap", gap_run, GAP + 1);

      // Reset pulsed during RX
      resetDut();
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("abort_in_rx", serial_state, 6);
      applyStimulus(1'b1, 1'b0);
      checkOutput("abort_sstate", serial_state, 0);
      checkOutput("abort_astate", adc_state, 0);
      checkOutput("abort_cs", cs, 1);
      checkOutput("abort_data", data, 0);
      checkOutput("abort_counter", counter, 'h295);
      checkOutput("abort_recd_tp", recd_tp, 0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("abort_next_ready", ready, 1);
      checkOutput("abort_next_data", data, 'h295);

      // en dropped during RX
      resetDut();
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("enlow_in_rx", serial_state, 6);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("enlow_ready", ready, 1);
      checkOutput("enlow_data", data, 'h295);
      low_cnt = 0; rdy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (!cs) low_cnt++;
         if (ready) rdy_cnt++;
      end
      checkOutput("enlow_no_frames", low_cnt, 0);
      checkOutput("enlow_no_ready", rdy_cnt, 0);
      checkOutput("enlow_idle", serial_state, 0);

      // Randomized run against the timeline model
      applyStimulus(1'b1, 1'b0);
      modelStep(1'b1, 1'b0);
      e = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) e = ~e;
         r = ($urandom_range(0, 179) == 0);
         applyStimulus(r, e);
         modelStep(r, e);
         checkOutput("rnd_cs", cs, !(off >= 1 && off <= 15));
         checkOutput("rnd_ready", ready, (off == 16));
         checkOutput("rnd_din", Din, (off >= 1 && off <= 4) ? int'(din_seq[4 - off]) : 0);
         checkOutput("rnd_time_out", time_out, (off >= 17) ? off - 17 : 0);
         checkOutput("rnd_data", data, dexp_a);
         checkOutput("rnd_counter", counter, samp_a);
         checkOutput("rnd_w_data", w_data, dexp_b);
         checkOutput("rnd_w_counter", w_counter, samp_b);
         if (off >= 5 && off <= 15)
            checkOutput("rnd_dout", Dout, (off == 5) ? 0 : ((samp_a >> (15 - off)) & 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adc_serial_link.md
# adc_serial_link

Serial link between a 10-bit SPI-style ADC master (`serial`) and a behavioural MCP3002-style ADC model (`adc_sim`), both running on the system clock with one bit per clock. `serial` issues a 4-bit command, receives a null bit plus 10 data bits MSB-first and presents the result with a ready pulse. `adc_sim` decodes the command and returns an incrementing sample. The pair sits below the LED-strip DSP front end.

## Interface
- serial `CH`, 1'b0: ODD/SIGN channel bit sent in the command.
- serial `GAP`, 20: WAIT cycles between conversions.
- adc_sim `INIT`, 10'h295: sample value after reset.
- Clocking (both modules): one clock; reset is synchronous and active-high.
- serial ports:
  - `clk` in 1: clock.
  - `rst` in 1: reset.
  - `en` in 1: enable conversions.
  - `cs` out 1: chip select, active low.
  - `Din` out 1: command bit to ADC.
  - `Dout` in 1: data bit from ADC.
  - `ready` out 1: one-cycle result-valid pulse.
  - `data` out 10: last result.
  - `state` out 4: FSM state code.
  - `time_out` out 10: WAIT cycle counter.
- adc_sim ports:
  - `clk` in 1: clock.
  - `rst` in 1: reset.
  - `Din` in 1: command bit.
  - `cs` in 1: chip select.
  - `Dout` out 1: data bit, tri-state (z) when not transmitting.
  - `recd_tp` out 4: received command {start,SGL,ODD,MSBF}.
  - `state` out 4: FSM state code.
  - `counter` out 10: sample to be sent next.

## Operation
- serial FSM; `cs`/`Din` are Moore-decoded from the state register:
  - 0 IDLE: `cs`=1, `Din`=0. `en`=1 -> START.
  - 1 START: `cs`=0, `Din`=1.
  - 2 SGL: `Din`=1.
  - 3 ODD: `Din`=`CH`.
  - 4 MSBF: `Din`=1.
  - 5 NULL: `Dout` ignored.
  - 6 RX: shift `Dout` into a 10-bit register for 10 cycles, MSB first.
  - 7 DONE: `cs`=1, `data`<=shift register, `ready`=1.
  - 8 WAIT: `cs`=1, `time_out` increments from 0. At `time_out`==`GAP`-1 -> START if `en`=1, else IDLE. `time_out` clears on exit.
- adc_sim FSM, sampling on each rising edge:
  - 0 IDLE: `Dout`=z. `cs`=0 and `Din`=1 -> CFG, `recd_tp[3]`<=1.
  - 1 CFG: shift 3 `Din` bits into `recd_tp[2:0]` -> NULL.
  - 2 NULL: `Dout`=0.
  - 3 TX: `Dout`=`counter[9-i]` for i=0..9.
  - 4 DONE: `Dout`=z, `counter`<=`counter`+1 (wraps 0x3FF->0x000) -> IDLE.
- adc_sim: `cs`=1 seen in any state other than IDLE/DONE -> IDLE, `Dout`=z, `counter` unchanged.
- `en` dropping mid-conversion: current conversion completes; the pair returns to IDLE after WAIT.
- `data` holds its value between DONE states.

## Timing
- Reset values: `cs`=1, `Din`=0, `ready`=0, `data`=0, `time_out`=0, serial `state`=0, `Dout`=z, `recd_tp`=0, `counter`=`INIT`, adc `state`=0.
- `en` sampled at edge k -> `cs` low for cycles k+1..k+15 (4 command, 1 null, 10 data).
- `ready` pulses in cycle k+16.
- Back-to-back period with `en` held: 16+`GAP` cycles (36 by default).
- adc state changes on the edge that samples the bit; master samples `Dout` at the end of each RX cycle, so both FSMs stay lock-stepped.
- Reset mid-operation: both FSMs return to reset values on the next edge.

## Structure
- Shared package `adc_link_pkg`: state encodings of both FSMs, command constants (START=1, SGL=1, MSBF=1), data width 10.
- `adc_sim` is a verification model and stays a separate module.
- `adc_serial_link` top instantiates `serial` and `adc_sim`, wiring `cs`, `Din` and `Dout`.
- No further sub-modules.

## Test plan
- Reset: `rst` held 2 cycles -> `cs`=1, `Dout`=z, `ready`=0, `data`=0, `counter`=0x295.
- Single conversion: `en`=1, one pulse -> `Din` sequence 1,1,0,1; `recd_tp`=4'b1101; `Dout` = null 0 then 1010010101; `ready` at k+16; `data`=0x295; `counter`=0x296.
- Continuous: `en` held 80 cycles -> `data` 0x295 then 0x296; `time_out` reaches 19; `cs` high for 21 cycles between frames.
- Wrap: `INIT`=0x3FF, two conversions -> `data`=0x3FF then 0x000.
- Abort: `rst` pulsed during RX -> reset values, `data` unchanged from 0; next conversion returns `INIT`.
- `en` low during RX -> frame completes with `ready`, then IDLE with `cs`=1 and no further frames.
